// File: rtl/smg_scan_decoder_module_if.sv
// Display scan bus (segment lines + digit selects) and the decoded result.
//
// Signalling: the master drives Row_Scan_Sig/Column_Scan_Sig freely with no
// flow control. The slave presents Number_Data/Number_Valid as level outputs.
// Number_Update is a one-cycle strobe marking a newly committed Data/Valid
// pair. Decode_Err is a one-cycle strobe per bad pattern or bad select.
// No ready exists; the receiver cannot back-pressure the display.
// dbg_state exposes the frame FSM for observation.
interface smg_scan_decoder_module_if;
  logic [7:0] Row_Scan_Sig;
  logic [1:0] Column_Scan_Sig;
  logic [7:0] Number_Data;
  logic       Number_Valid;
  logic       Number_Update;
  logic       Decode_Err;
  logic [0:0] dbg_state;

  modport master (
    output Row_Scan_Sig, Column_Scan_Sig,
    input  Number_Data, Number_Valid, Number_Update, Decode_Err, dbg_state
  );

  modport slave (
    input  Row_Scan_Sig, Column_Scan_Sig,
    output Number_Data, Number_Valid, Number_Update, Decode_Err, dbg_state
  );
endinterface

// File: rtl/smg_scan_decoder_module.sv
// Receive end of a 2-digit multiplexed 7-segment scan bus. Rebuilds the
// displayed value 0..99, debounces it across frames and flags bad patterns.
module smg_scan_decoder_module #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int STABLE_FRAMES  = 3,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic                      CLK,
  input logic                      RST_N,
  smg_scan_decoder_module_if.slave bus
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int CW = $clog2(STABLE_FRAMES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TO_HIT      = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_MAX  = CW'(STABLE_FRAMES);

  typedef enum logic [0:0] {HUNT = 1'b0, HAVE_TEN = 1'b1} state_e;

  // Returns {legal, digit}; the decimal point is not part of the pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h40:   seg_decode = {1'b1, 4'd0};
      7'h79:   seg_decode = {1'b1, 4'd1};
      7'h24:   seg_decode = {1'b1, 4'd2};
      7'h30:   seg_decode = {1'b1, 4'd3};
      7'h19:   seg_decode = {1'b1, 4'd4};
      7'h12:   seg_decode = {1'b1, 4'd5};
      7'h02:   seg_decode = {1'b1, 4'd6};
      7'h78:   seg_decode = {1'b1, 4'd7};
      7'h00:   seg_decode = {1'b1, 4'd8};
      7'h10:   seg_decode = {1'b1, 4'd9};
      default: seg_decode = 5'd0;
    endcase
  endfunction

  logic [6:0]    row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic [1:0]    col_s1_q, col_s1_d, col_s2_q, col_s2_d, col_prev_q, col_prev_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] to_q, to_d;
  state_e        state_q, state_d;
  logic [3:0]    ten_q, ten_d;
  logic [6:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d, upd_q, upd_d, err_q, err_d;

  logic       sel_chg, sample, pat_err, sel_err, to_hit, abort, frame;
  logic [4:0] seg;
  logic [6:0] frame_val;

  // Next-state: sync, settle/timeout counters, frame FSM, debounce and commit.
  always_comb begin
    row_s1_d   = bus.Row_Scan_Sig[6:0];
    row_s2_d   = row_s1_q;
    col_s1_d   = bus.Column_Scan_Sig;
    col_s2_d   = col_s1_q;
    col_prev_d = col_s2_q;
    state_d    = state_q;
    ten_d      = ten_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    upd_d      = 1'b0;

    sel_chg  = (col_s2_q != col_prev_q);
    settle_d = sel_chg ? '0 : ((settle_q == SETTLE_MAX) ? settle_q : settle_q + 1'b1);
    to_d     = sel_chg ? '0 : ((to_q == TO_MAX) ? to_q : to_q + 1'b1);

    // One sample per dwell; the counter only passes SETTLE_LAST once.
    sample    = !sel_chg && (settle_q == SETTLE_LAST) &&
                (col_s2_q == 2'b01 || col_s2_q == 2'b10);
    seg       = seg_decode(row_s2_q);
    pat_err   = sample && !seg[4];
    sel_err   = sel_chg && (col_s2_q == 2'b00);
    to_hit    = !sel_chg && (to_q == TO_HIT);
    abort     = pat_err || sel_err || to_hit;
    frame     = sample && seg[4] && (col_s2_q == 2'b10) && (state_q == HAVE_TEN);
    frame_val = ({3'b000, ten_q} * 7'd10) + {3'b000, seg[3:0]};
    err_d     = pat_err || sel_err;

    if (sample && seg[4]) begin
      if (col_s2_q == 2'b01) begin
        state_d = HAVE_TEN;
        ten_d   = seg[3:0];
      end else if (state_q == HAVE_TEN) begin
        state_d = HUNT;
      end
    end

    if (frame) begin
      if (frame_val == cand_q) begin
        cnt_d = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cand_d = frame_val;
        cnt_d  = CW'(1);
      end
    end

    // Aborting events win over a commit pending in the same cycle.
    if (!abort && (cnt_q == STABLE_MAX) && (!valid_q || (cand_q != data_q[6:0]))) begin
      data_d  = {1'b0, cand_q};
      valid_d = 1'b1;
      upd_d   = 1'b1;
    end

    if (abort) begin
      state_d = HUNT;
      cnt_d   = '0;
    end

    if (to_hit) begin
      valid_d = 1'b0;
      upd_d   = valid_q;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      row_s1_q   <= '0;
      row_s2_q   <= '0;
      col_s1_q   <= '0;
      col_s2_q   <= '0;
      col_prev_q <= '0;
      settle_q   <= '0;
      to_q       <= '0;
      state_q    <= HUNT;
      ten_q      <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      row_s1_q   <= row_s1_d;
      row_s2_q   <= row_s2_d;
      col_s1_q   <= col_s1_d;
      col_s2_q   <= col_s2_d;
      col_prev_q <= col_prev_d;
      settle_q   <= settle_d;
      to_q       <= to_d;
      state_q    <= state_d;
      ten_q      <= ten_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
    end
  end

  assign bus.Number_Data   = data_q;
  assign bus.Number_Valid  = valid_q;
  assign bus.Number_Update = upd_q;
  assign bus.Decode_Err    = err_q;
  assign bus.dbg_state     = state_q;
endmodule
